// File: rtl/ks_delay_multi.sv
`default_nettype none
// ks_delay_multi: multi-voice Karplus-Strong delay line, one ring buffer per string,
// fractional delay by linear interpolation between adjacent taps. Rev 1.0
module ks_delay_multi #(
  parameter  int WIDTH  = 24,
  parameter  int DEPTH  = 1000,
  parameter  int VOICES = 6,
  parameter  int FRAC   = 4,
  localparam int DW     = $clog2(DEPTH + 1) + FRAC
) (
  input  logic                      lrck,
  input  logic                      rst_n,
  input  logic [VOICES*WIDTH-1:0]   in,
  input  logic [VOICES*DW-1:0]      delay,
  input  logic [VOICES-1:0]         clr,
  output logic [VOICES*WIDTH-1:0]   out,
  output logic [VOICES-1:0]         primed
);

  localparam int AW = $clog2(DEPTH + 1);
  localparam int TW = AW + 1;
  localparam int IW = DW - FRAC;
  localparam int PW = WIDTH + 1 + FRAC;

  localparam logic [TW-1:0] LEN_T   = TW'(DEPTH + 1);
  localparam logic [TW-1:0] DEPTH_T = TW'(DEPTH);
  localparam logic [TW-1:0] ONE_T   = TW'(1);
  localparam logic [AW-1:0] LAST_A  = AW'(DEPTH);

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    logic [WIDTH-1:0]        mem [0:DEPTH];
    logic [AW-1:0]           wptr;
    logic [TW-1:0]           fill;
    logic [WIDTH-1:0]        y_q;

    logic [IW-1:0]           int_part;
    logic [FRAC-1:0]         frac_raw;
    logic [FRAC-1:0]         frac;
    logic [TW-1:0]           d0;
    logic [TW-1:0]           d1;
    logic [TW-1:0]           wext;
    logic [AW-1:0]           addr0;
    logic [AW-1:0]           addr1;
    logic signed [WIDTH-1:0] tap0;
    logic signed [WIDTH-1:0] tap1;
    logic signed [WIDTH:0]   diff;
    logic signed [PW-1:0]    prod;
    logic [WIDTH-1:0]        y;

    assign int_part = delay[v*DW+FRAC +: IW];
    assign frac_raw = delay[v*DW +: FRAC];

    always_comb begin
      d0   = TW'(int_part);
      frac = frac_raw;
      if (int_part == '0) begin
        d0   = ONE_T;
        frac = '0;
      end else if (TW'(int_part) > DEPTH_T) begin
        d0   = DEPTH_T;
        frac = '0;
      end
    end

    assign d1   = d0 + ONE_T;
    assign wext = {1'b0, wptr};

    // Tap k sits at (w - k) mod (DEPTH+1); tap DEPTH+1 is the slot about to be overwritten.
    assign addr0 = AW'((wext >= d0) ? (wext - d0) : (wext + LEN_T - d0));
    assign addr1 = AW'((wext >= d1) ? (wext - d1) : (wext + LEN_T - d1));

    // History is never reset in memory; the fill count alone hides stale entries.
    assign tap0 = (d0 <= fill) ? mem[addr0] : '0;
    assign tap1 = (d1 <= fill) ? mem[addr1] : '0;

    assign diff = {tap1[WIDTH-1], tap1} - {tap0[WIDTH-1], tap0};
    assign prod = PW'(diff) * PW'($signed({1'b0, frac}));
    assign y    = WIDTH'(PW'(tap0) + (prod >>> FRAC));

    always_ff @(posedge lrck) begin
      mem[wptr] <= clr[v] ? '0 : in[v*WIDTH +: WIDTH];
    end

    always_ff @(posedge lrck or negedge rst_n) begin
      if (!rst_n) begin
        wptr <= '0;
        fill <= '0;
        y_q  <= '0;
      end else begin
        wptr <= (wptr == LAST_A) ? '0 : wptr + 1'b1;
        if (clr[v]) begin
          fill <= '0;
          y_q  <= '0;
        end else begin
          y_q <= y;
          if (fill != LEN_T) begin
            fill <= fill + ONE_T;
          end
        end
      end
    end

    assign out[v*WIDTH +: WIDTH] = y_q;
    assign primed[v]             = (fill == LEN_T);
  end

endmodule
`default_nettype wire

// File: tb/tb_ks_delay_multi.sv
`default_nettype none
// tb_ks_delay_multi: randomized and directed checks of ks_delay_multi against an
// edge-indexed sample-history model. Rev 1.0
module tb_ks_delay_multi;
  localparam int WIDTH  = 24;
  localparam int DEPTH  = 8;
  localparam int VOICES = 2;
  localparam int FRAC   = 2;
  localparam int DW     = $clog2(DEPTH + 1) + FRAC;
  localparam int MAXN   = 4096;

  logic                    lrck = 1'b0;
  logic                    rst_n = 1'b1;
  logic [VOICES*WIDTH-1:0] in_bus = '0;
  logic [VOICES*DW-1:0]    delay_bus = '0;
  logic [VOICES-1:0]       clr_bus = '0;
  logic [VOICES*WIDTH-1:0] out_bus;
  logic [VOICES-1:0]       primed_bus;

  ks_delay_multi #(.WIDTH(WIDTH), .DEPTH(DEPTH), .VOICES(VOICES), .FRAC(FRAC)) dut (
    .lrck   (lrck),
    .rst_n  (rst_n),
    .in     (in_bus),
    .delay  (delay_bus),
    .clr    (clr_bus),
    .out    (out_bus),
    .primed (primed_bus)
  );

  always #5 lrck = ~lrck;

  // Model: every sample ever presented, indexed by edge; anything before vstart reads as 0.
  longint xh [VOICES][MAXN];
  int     vstart [VOICES];
  int     nedge = 0;
  longint exp_out [VOICES];
  bit     exp_pr [VOICES];
  bit     chk_en = 1'b0;
  int     tests = 0;
  int     fails = 0;

  function automatic longint xat(int v, int m);
    if (m < 0 || m < vstart[v]) return 0;
    return xh[v][m];
  endfunction

  function automatic longint dout(int v);
    logic signed [WIDTH-1:0] s;
    s = out_bus[v*WIDTH +: WIDTH];
    return longint'(s);
  endfunction

  task automatic model_reset();
    for (int v = 0; v < VOICES; v++) begin
      vstart[v]  = nedge;
      exp_out[v] = 0;
      exp_pr[v]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int v = 0; v < VOICES; v++) begin
      logic signed [WIDTH-1:0] s;
      logic [DW-1:0] dw;
      int ip, fp, dd;
      longint a, b;
      s  = in_bus[v*WIDTH +: WIDTH];
      dw = delay_bus[v*DW +: DW];
      ip = int'(dw) >> FRAC;
      fp = int'(dw) % (1 << FRAC);
      if (ip == 0) begin dd = 1; fp = 0; end
      else if (ip > DEPTH) begin dd = DEPTH; fp = 0; end
      else dd = ip;
      if (clr_bus[v]) begin
        xh[v][nedge] = 0;
        vstart[v]    = nedge + 1;
        exp_out[v]   = 0;
        exp_pr[v]    = 1'b0;
      end else begin
        xh[v][nedge] = longint'(s);
        a = xat(v, nedge - dd);
        b = xat(v, nedge - dd - 1);
        exp_out[v] = a + (((b - a) * fp) >>> FRAC);
        exp_pr[v]  = (nedge - vstart[v] + 1) >= DEPTH + 1;
      end
    end
    nedge++;
  endtask

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge lrck) begin
    if (chk_en) begin
      for (int v = 0; v < VOICES; v++) begin
        logic [WIDTH-1:0] e;
        longint ev;
        ev = exp_out[v];
        e  = ev[WIDTH-1:0];
        tests++;
        if (out_bus[v*WIDTH +: WIDTH] !== e) begin
          fails++;
          $display("FAIL model_out%0d edge %0d: got %0d, expected %0d", v, nedge - 1, dout(v), ev);
        end
        tests++;
        if (primed_bus[v] !== exp_pr[v]) begin
          fails++;
          $display("FAIL model_primed%0d edge %0d: got %0b, expected %0b", v, nedge - 1, primed_bus[v], exp_pr[v]);
        end
      end
    end
  end

  task automatic step(input longint x0, input longint x1, input int d0, input int d1, input logic [1:0] c);
    @(negedge lrck);
    in_bus[0 +: WIDTH]      = WIDTH'(x0);
    in_bus[WIDTH +: WIDTH]  = WIDTH'(x1);
    delay_bus[0 +: DW]      = DW'(d0);
    delay_bus[DW +: DW]     = DW'(d1);
    clr_bus                 = c;
    @(posedge lrck);
    model_edge();
    #1;
  endtask

  // Asserts reset between edges, checks the outputs with no edge, holds across one edge.
  task automatic do_reset();
    @(negedge lrck);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_out0", dout(0), 0);
    check("async_rst_out1", dout(1), 0);
    check("async_rst_primed", longint'(primed_bus), 0);
    model_reset();
    @(posedge lrck);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    model_reset();
    chk_en = 1'b1;
    @(posedge lrck);
    #1 rst_n = 1'b1;

    // Integer delay, crossing the wrap several times.
    do_reset();
    for (int n = 0; n < 40; n++) begin
      step(n + 1, $urandom_range(5000), 3 << FRAC, (5 << FRAC) | 1, 2'b00);
      if (n == 2)  check("int_edge2", dout(0), 0);
      if (n == 3)  check("int_edge3", dout(0), 1);
      if (n == 7)  check("int_primed7", primed_bus[0], 0);
      if (n == 8)  check("int_primed8", primed_bus[0], 1);
      if (n == 39) check("int_edge39", dout(0), 37);
    end

    // Fractional delay 2.5 on a ramp.
    do_reset();
    for (int n = 0; n < 16; n++) begin
      step(4 * n, -7 * n, (2 << FRAC) | 2, (2 << FRAC) | 2, 2'b00);
      if (n == 2)  check("frac_edge2", dout(0), 0);
      if (n == 3)  check("frac_edge3", dout(0), 2);
      if (n == 5)  check("frac_edge5", dout(0), 10);
      if (n == 12) check("frac_edge12", dout(0), 38);
    end

    // Interpolation rounds toward -inf.
    do_reset();
    for (int n = 0; n < 6; n++) begin
      step((n == 1) ? -3 : 0, 0, (1 << FRAC) | 1, 0, 2'b00);
      if (n == 2) check("round_edge2", dout(0), -3);
      if (n == 3) check("round_edge3", dout(0), -1);
    end

    // Clamping: I=0 acts as 1, I=15 acts as DEPTH, fraction ignored in both.
    do_reset();
    for (int n = 0; n < 21; n++) begin
      step(7 * n + 1, 5 * n - 100, 3, (15 << FRAC) | 3, 2'b00);
      if (n == 7)  check("clamp_hi_edge7", dout(1), 0);
      if (n == 8)  check("clamp_hi_edge8", dout(1), -100);
      if (n == 10) check("clamp_lo_edge10", dout(0), 64);
      if (n == 10) check("clamp_hi_edge10", dout(1), -90);
    end

    // Per-voice clear on voice 1 at edge 20.
    do_reset();
    for (int n = 0; n < 41; n++) begin
      step(3 * n + 2, 1000 - 11 * n, (4 << FRAC) | 1, 3 << FRAC, (n == 20) ? 2'b10 : 2'b00);
      if (n == 19) check("clr_primed19", primed_bus[1], 1);
      if (n == 20) check("clr_out20", dout(1), 0);
      if (n == 20) check("clr_primed20", primed_bus[1], 0);
      if (n == 23) check("clr_out23", dout(1), 0);
      if (n == 24) check("clr_out24", dout(1), 769);
      if (n == 28) check("clr_primed28", primed_bus[1], 0);
      if (n == 29) check("clr_primed29", primed_bus[1], 1);
      if (n == 22) check("clr_v0_edge22", dout(0), 55);
    end

    // Reset in the middle of random traffic; history must read as zeros afterwards.
    for (int n = 0; n < 12; n++)
      step($urandom_range(100000), $urandom_range(100000), 2 << FRAC, 1 << FRAC, 2'b00);
    do_reset();
    for (int n = 0; n < 4; n++) begin
      step(n + 10, n + 20, 2 << FRAC, 1 << FRAC, 2'b00);
      if (n == 1) check("rst_hist_edge1", dout(0), 0);
      if (n == 2) check("rst_hist_edge2", dout(0), 10);
      if (n == 1) check("rst_hist_v1_edge1", dout(1), 20);
    end

    // Random samples, delays and clears.
    for (int n = 0; n < 600; n++) begin
      logic [WIDTH-1:0] r0, r1;
      logic [1:0] c;
      r0 = WIDTH'($urandom);
      r1 = WIDTH'($urandom);
      c[0] = ($urandom_range(29) == 0);
      c[1] = ($urandom_range(29) == 0);
      step(longint'($signed(r0)), longint'($signed(r1)),
           int'($urandom_range((1 << DW) - 1)), int'($urandom_range((1 << DW) - 1)), c);
    end

    @(negedge lrck);
    #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
